crc_sram_checker: RTL

- Read-side initiator for the 32x1024 single-port SRAM macro (freepdk45_sram_4kbytes_1rw_32x1024_8).
- On a start pulse, streams a contiguous word range out of the SRAM through the existing crc32 combinational block and folds each word into a running CRC-32.
- Reports the final CRC and whether it equals an expected value.
- Sits between the accelerator control registers and the SRAM read port; the SRAM is the responder, this block is the initiator.

---
 rtl/crc_sram_checker_if.sv | 39 +++
 rtl/crc_sram_checker.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/crc_sram_checker_if.sv
// rtl/crc_sram_checker_if.sv - SRAM read/write port bundle between the CRC checker and the SRAM macro
//
// Signals (naming follows the SRAM macro port 0):
//   csb0    chip select, active low          (initiator -> SRAM)
//   web0    write enable, active low         (initiator -> SRAM)
//   wmask0  byte write mask                  (initiator -> SRAM)
//   addr0   word address                     (initiator -> SRAM)
//   din0    write data                       (initiator -> SRAM)
//   dout0   read data, one cycle after addr0 (SRAM -> initiator)
// Modports: master = initiator (checker), slave = SRAM model/macro.
interface crc_sram_checker_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) ();
    logic                  csb0;
    logic                  web0;
    logic [3:0]            wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;

    modport master (
        output csb0,
        output web0,
        output wmask0,
        output addr0,
        output din0,
        input  dout0
    );

    modport slave (
        input  csb0,
        input  web0,
        input  wmask0,
        input  addr0,
        input  din0,
        output dout0
    );
endinterface

// File: rtl/crc_sram_checker.sv
// rtl/crc_sram_checker.sv - streams an SRAM word range through CRC-32 and compares against a reference
//
// Ports:
//   clk0          clock, shared with the SRAM
//   rst_n         asynchronous active-low reset
//   start         one-cycle request, sampled only in IDLE
//   abort         cancels a run in READ or DRAIN
//   base_addr     first word address (sampled with start)
//   num_words     word count 0..2^ADDR_WIDTH (sampled with start)
//   expected_crc  reference CRC (sampled with start)
//   busy          high in READ, DRAIN and DONE
//   done          one-cycle completion pulse
//   crc_value     final CRC after XOROUT, held until the next completion
//   crc_match     crc_value == latched expected_crc, valid with done and held
//   sram          SRAM port 0 (master side); read only
module crc_sram_checker #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] CRC_INIT   = 32'hFFFF_FFFF,
    parameter logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic [31:0]           expected_crc,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           crc_value,
    output logic                  crc_match,
    crc_sram_checker_if.master    sram
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   num_q;
    logic [31:0]           expected_q;
    logic [ADDR_WIDTH:0]   issued;
    logic [ADDR_WIDTH:0]   issued_inc;
    logic                  rd_valid;
    logic [31:0]           crc_reg;

    logic                  csb;
    logic                  issue;
    logic                  load;
    logic [31:0]           crc_fold;
    logic [31:0]           crc_after;
    logic [31:0]           finish_value;
    logic [31:0]           finish_expect;

    // Raw reflected CRC-32 update (poly 0xEDB88320), no inversion. XORing the
    // whole word up front and shifting 32 times is equivalent to feeding the
    // bytes LSB-first, byte 0 first.
    function automatic logic [31:0] crc32(input logic [31:0] data_in,
                                          input logic [31:0] init);
        logic [31:0] c;
        c = init ^ data_in;
        for (int i = 0; i < 32; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    assign issued_inc = issued + 1'b1;
    assign crc_fold   = crc32(sram.dout0, crc_reg);

    // The word read in the previous cycle is still in flight when leaving
    // DRAIN, so the final value includes it if the read-valid flag is set.
    assign crc_after  = rd_valid ? crc_fold : crc_reg;

    // A zero-length run goes straight from IDLE to DONE, before crc_reg and
    // expected_q have taken their new values, so use the seed and the live
    // input in that case.
    assign finish_value  = (state == S_IDLE) ? (CRC_INIT ^ CRC_XOROUT)
                                             : (crc_after ^ CRC_XOROUT);
    assign finish_expect = (state == S_IDLE) ? expected_crc : expected_q;

    always_comb begin
        state_next = state;
        csb        = 1'b1;
        issue      = 1'b0;
        load       = 1'b0;
        case (state)
            S_IDLE: begin
                // abort is ignored here, so start wins when both are high
                if (start) begin
                    load       = 1'b1;
                    state_next = (num_words == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else begin
                    csb   = 1'b0;
                    issue = 1'b1;
                    if (issued_inc == num_q) begin
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_next = abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            base_q     <= '0;
            num_q      <= '0;
            expected_q <= '0;
            issued     <= '0;
            rd_valid   <= 1'b0;
            crc_reg    <= '0;
            crc_value  <= '0;
            crc_match  <= 1'b0;
        end else begin
            state    <= state_next;
            rd_valid <= ~csb;

            if (load) begin
                base_q     <= base_addr;
                num_q      <= num_words;
                expected_q <= expected_crc;
                issued     <= '0;
            end else if (issue) begin
                issued <= issued_inc;
            end

            // On abort the in-flight word is dropped.
            if (load) begin
                crc_reg <= CRC_INIT;
            end else if (rd_valid && !abort) begin
                crc_reg <= crc_fold;
            end

            if (state_next == S_DONE) begin
                crc_value <= finish_value;
                crc_match <= (finish_value == finish_expect);
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // csb0 is combinational so abort and reset release the SRAM at once.
    // Address wraps naturally by truncation to ADDR_WIDTH bits.
    assign sram.csb0   = csb;
    assign sram.web0   = 1'b1;
    assign sram.wmask0 = 4'b0000;
    assign sram.addr0  = base_q + issued[ADDR_WIDTH-1:0];
    assign sram.din0   = {DATA_WIDTH{1'b0}};

endmodule
